// File: rtl/vga_frame_capture.sv
// VGA receive-side monitor: captures active pixels into a frame RAM
// and reports a per-frame checksum plus line/overflow timing errors.
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  localparam int X_W = $clog2(H_ACTIVE + 1),
  localparam int Y_W = $clog2(V_ACTIVE + 1)
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iHS,
  input  logic              iVS,
  input  logic              iBLANK_n,
  input  logic [7:0]        iB,
  input  logic [7:0]        iG,
  input  logic [7:0]        iR,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [23:0]       oWR_DATA,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic              oFRAME_DONE,
  output logic [31:0]       oFRAME_SUM,
  output logic              oFRAME_OK,
  output logic              oLINE_ERR,
  output logic              oOVF_ERR
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL =
    CNT_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [X_W-1:0] H_X = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_Y = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0] X_MAX = '1;

  typedef enum logic [1:0] {
    SEEK,
    VSYNC,
    ACTIVE
  } state_t;

  state_t state, state_n;

  logic        vs_q, vs_p;
  logic        blank_q, blank_p;
  logic [23:0] pix_q;

  logic [X_W-1:0]   x, x_n;
  logic [Y_W-1:0]   y, y_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      sum, sum_n;
  logic             ferr, ferr_n;

  logic cap, ovf, line_bad, frame_end;
  logic vs_fall, vs_rise, blank_fall;
  logic [ADDR_W-1:0] addr_c;

  // Line boundaries come from BLANK_n; HS is not needed for capture.
  logic hs_unused;
  assign hs_unused = iHS;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q    <= 1'b1;
      vs_p    <= 1'b1;
      blank_q <= 1'b0;
      blank_p <= 1'b0;
      pix_q   <= '0;
    end else begin
      vs_q    <= iVS;
      vs_p    <= vs_q;
      blank_q <= iBLANK_n;
      blank_p <= blank_q;
      pix_q   <= {iB, iG, iR};
    end
  end

  assign vs_fall    = vs_p & ~vs_q;
  assign vs_rise    = ~vs_p & vs_q;
  assign blank_fall = blank_p & ~blank_q;
  assign addr_c     = ADDR_W'(y) * ADDR_W'(H_ACTIVE)
                    + ADDR_W'(x);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) state <= SEEK;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cap       = 1'b0;
    ovf       = 1'b0;
    line_bad  = 1'b0;
    frame_end = 1'b0;
    x_n       = x;
    y_n       = y;
    cnt_n     = cnt;
    sum_n     = sum;
    ferr_n    = ferr;
    unique case (state)
      SEEK: begin
        if (vs_fall) state_n = VSYNC;
      end
      VSYNC: begin
        x_n    = '0;
        y_n    = '0;
        cnt_n  = '0;
        sum_n  = '0;
        ferr_n = 1'b0;
        if (vs_rise) state_n = ACTIVE;
      end
      ACTIVE: begin
        if (blank_q) begin
          if (cnt < TOTAL) begin
            cap   = 1'b1;
            sum_n = sum + 32'(pix_q);
            cnt_n = cnt + CNT_W'(1);
            x_n   = (x == X_MAX) ? x : x + X_W'(1);
          end else begin
            ovf    = 1'b1;
            ferr_n = 1'b1;
          end
        end
        // A line cut short by VS still gets its length checked.
        if (blank_fall || (vs_fall && blank_q)) begin
          if (x_n != H_X) begin
            line_bad = 1'b1;
            ferr_n   = 1'b1;
          end
          x_n = '0;
          y_n = (y == V_Y) ? y : y + Y_W'(1);
        end
        if (vs_fall) begin
          frame_end = 1'b1;
          state_n   = VSYNC;
        end
      end
      default: state_n = SEEK;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x    <= '0;
      y    <= '0;
      cnt  <= '0;
      sum  <= '0;
      ferr <= 1'b0;
    end else begin
      x    <= x_n;
      y    <= y_n;
      cnt  <= cnt_n;
      sum  <= sum_n;
      ferr <= ferr_n;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oWR_EN      <= 1'b0;
      oWR_ADDR    <= '0;
      oWR_DATA    <= '0;
      oX          <= '0;
      oY          <= '0;
      oFRAME_DONE <= 1'b0;
      oFRAME_SUM  <= '0;
      oFRAME_OK   <= 1'b0;
      oLINE_ERR   <= 1'b0;
      oOVF_ERR    <= 1'b0;
    end else begin
      oWR_EN      <= cap;
      oFRAME_DONE <= frame_end;
      if (cap) begin
        oWR_ADDR <= addr_c;
        oWR_DATA <= pix_q;
        oX       <= x;
        oY       <= y;
      end
      if (frame_end) begin
        oFRAME_SUM <= sum_n;
        oFRAME_OK  <= (y_n == V_Y) && (cnt_n == TOTAL)
                      && !ferr_n;
      end
      if (line_bad) oLINE_ERR <= 1'b1;
      if (ovf)      oOVF_ERR  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a reduced 8x4 frame:
// nominal, gradient, short line, truncated line, overflow, reset.
module tb_vga_frame_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;
  localparam logic [23:0] CPIX = 24'h150088;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hs, vs, blank;
  logic [7:0]    b, g, r;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [3:0]    x_o;
  logic [2:0]    y_o;
  logic          done;
  logic [31:0]   fsum;
  logic          fok, lerr, ovf;

  int n_cmp = 0;
  int n_err = 0;

  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          frame_wr = 0;
  logic [31:0] sum_seen = '0;
  logic        ok_seen = 1'b0;
  logic [63:0] last_addr = '0;
  bit          chk_wr = 1'b0;
  bit          grad = 1'b0;

  vga_frame_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W(AW)
  ) dut (
    .iVGA_CLK(clk),
    .iRST_n(rst_n),
    .iHS(hs),
    .iVS(vs),
    .iBLANK_n(blank),
    .iB(b),
    .iG(g),
    .iR(r),
    .oWR_EN(wr_en),
    .oWR_ADDR(wr_addr),
    .oWR_DATA(wr_data),
    .oX(x_o),
    .oY(y_o),
    .oFRAME_DONE(done),
    .oFRAME_SUM(fsum),
    .oFRAME_OK(fok),
    .oLINE_ERR(lerr),
    .oOVF_ERR(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      if (chk_wr) begin
        check("wr_addr", 64'(wr_addr), 64'(wr_cnt));
        check("wr_data", 64'(wr_data),
              grad ? 64'(wr_cnt) : 64'(CPIX));
        check("wr_x", 64'(x_o), 64'(wr_cnt % H));
        check("wr_y", 64'(y_o), 64'(wr_cnt / H));
      end
      last_addr = 64'(wr_addr);
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      frame_wr = wr_cnt;
      wr_cnt   = 0;
      sum_seen = fsum;
      ok_seen  = fok;
    end
  end

  task automatic drive(input logic bl, input logic [23:0] px);
    blank = bl;
    {b, g, r} = px;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs = 1'b0;
    repeat (4) drive(1'b0, 24'h0);
    vs = 1'b1;
    repeat (3) drive(1'b0, 24'h0);
  endtask

  task automatic send_line(input int len, input int row);
    for (int c = 0; c < len; c++)
      drive(1'b1, grad ? 24'(row * H + c) : CPIX);
    repeat (3) drive(1'b0, 24'h0);
  endtask

  task automatic send_frame(input int nl, input int short_row);
    for (int rr = 0; rr < nl; rr++)
      send_line((rr == short_row) ? H - 1 : H, rr);
  endtask

  task automatic check_frame(input string tag, input int n,
                             input int wr, input logic [31:0] s,
                             input logic ok);
    check({tag, "_done"}, 64'(done_cnt), 64'(n));
    check({tag, "_writes"}, 64'(frame_wr), 64'(wr));
    check({tag, "_sum"}, 64'(sum_seen), 64'(s));
    check({tag, "_hold"}, 64'(fsum), 64'(s));
    check({tag, "_ok"}, 64'(ok_seen), 64'(ok));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_data"}, 64'(wr_data), 64'd0);
    check({tag, "_x"}, 64'(x_o), 64'd0);
    check({tag, "_y"}, 64'(y_o), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_sum"}, 64'(fsum), 64'd0);
    check({tag, "_ok"}, 64'(fok), 64'd0);
    check({tag, "_lerr"}, 64'(lerr), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    hs    = 1'b1;
    vs    = 1'b1;
    blank = 1'b0;
    {b, g, r} = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    repeat (10) drive(1'b1, CPIX);
    repeat (3) drive(1'b0, 24'h0);
    check("seek_writes", 64'(wr_cnt), 64'd0);
    chk_wr = 1'b1;
    vs_pulse();
    check("seek_done", 64'(done_cnt), 64'd0);

    send_frame(V, -1);
    vs_pulse();
    check_frame("const1", 1, 32, 32'(32 * CPIX), 1'b1);
    check("const1_last", last_addr, 64'd31);
    send_frame(V, -1);
    vs_pulse();
    check_frame("const2", 2, 32, 32'(32 * CPIX), 1'b1);

    grad = 1'b1;
    send_frame(V, -1);
    vs_pulse();
    check_frame("grad", 3, 32, 32'd496, 1'b1);
    check("grad_lerr", 64'(lerr), 64'd0);
    check("grad_ovf", 64'(ovf), 64'd0);
    grad = 1'b0;
    chk_wr = 1'b0;

    send_frame(V, 1);
    vs_pulse();
    check_frame("short", 4, 31, 32'(31 * CPIX), 1'b0);
    check("short_lerr", 64'(lerr), 64'd1);
    send_frame(V, -1);
    vs_pulse();
    check_frame("recover", 5, 32, 32'(32 * CPIX), 1'b1);
    check("recover_lerr", 64'(lerr), 64'd1);

    for (int rr = 0; rr < 3; rr++) send_line(H, rr);
    repeat (5) drive(1'b1, CPIX);
    vs = 1'b0;
    drive(1'b1, CPIX);
    vs_pulse();
    check_frame("trunc", 6, 30, 32'(30 * CPIX), 1'b0);

    send_frame(V + 1, -1);
    vs_pulse();
    check_frame("ovf", 7, 32, 32'(32 * CPIX), 1'b0);
    check("ovf_flag", 64'(ovf), 64'd1);

    send_frame(2, -1);
    repeat (3) drive(1'b1, CPIX);
    rst_n = 1'b0;
    #2;
    check_idle("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_cnt = 0;
    repeat (5) drive(1'b1, CPIX);
    repeat (3) drive(1'b0, 24'h0);
    send_line(H, 3);
    vs_pulse();
    check("midrst_nodone", 64'(done_cnt), 64'd7);
    check("midrst_nowr", 64'(wr_cnt), 64'd0);
    send_frame(V, -1);
    vs_pulse();
    check_frame("resume", 8, 32, 32'(32 * CPIX), 1'b1);
    check("resume_lerr", 64'(lerr), 64'd0);
    check("resume_ovf", 64'(ovf), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
